dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// Shares the single 64-bit data memory between two requesters: port 0 is the core MEM stage and port 1 is the
// debug/program loader. At most one access is issued per cycle, with round-robin priority. A bounded lock
// keeps a requester's sequence (e.g. load-modify-store) atomic. Misaligned accesses are rejected without
// touching memory. The block sits between the core's DMEM signals and the memory array.
// PARAMETERS
// ADDR_W    64  byte-address width
// DATA_W    64  data word width; memory is DATA_W/8-byte word addressed (addr[2:0] is the offset)
// LOCK_MAX  16  maximum consecutive cycles a port may hold the lock before it is revoked
// PORTS
// clk        in   1         clock, all state updates on rising edge
// rst        in   1         synchronous reset, active-low
// req_valid  in   2         per-port request valid (bit i = port i)
// req_ready  out  2         per-port accept; a transfer occurs when valid&ready are both high
// req_we     in   2         1 = store, 0 = load
// req_lock   in   2         request the lock to be held after this access
// req_addr   in   2*ADDR_W  port i address at [i*ADDR_W +: ADDR_W]
// req_wdata  in   2*DATA_W  port i store data at [i*DATA_W +: DATA_W]
// rsp_valid  out  2         one-cycle response strobe for port i
// rsp_err    out  2         response is a misalignment error (qualified by rsp_valid)
// rsp_rdata  out  DATA_W    load data, shared, qualified by rsp_valid; 0 for stores and errors
// mem_en     out  1         memory access this cycle
// mem_we     out  1         memory write enable
// mem_addr   out  ADDR_W    memory byte address
// mem_wdata  out  DATA_W    memory write data
// mem_rdata  in   DATA_W    read data, valid the cycle after mem_en&!mem_we
// BEHAVIOUR
// - Reset (rst==0 at clk edge): state=ARB, ptr=0, lock_cnt=0, response pipe cleared. During reset all
//   outputs are 0 (req_ready, rsp_*, mem_*). In-flight responses are dropped and are never delivered.
// - req_ready is combinational from state/ptr/req_valid/req_lock. At most one bit is high. It is never high
//   for a port whose req_valid is low.
// - FSM states:
//   ARB:   winner = ptr if req_valid[ptr], else the other port if it is valid. On accept: ptr <= ~winner;
//          if req_lock[winner] is set, go to LOCKw with lock_cnt <= 1.
//   LOCK0 / LOCK1: only the lock owner can get req_ready. Other cycles: lock_cnt increments per cycle,
//          whether or not the owner is valid.
//   Leave LOCKx to ARB when x has an accepted request with req_lock=0 (that access is still performed),
//          or when lock_cnt reaches LOCK_MAX. At a forced exit, ptr <= other port, and a request from x
//          on that cycle is not accepted.
// - Accepted request with aligned addr (addr[2:0]==0):
//   - mem_en=1, mem_we=req_we, mem_addr/mem_wdata are driven combinationally in the same cycle.
//   - Response one cycle later: rsp_valid[owner]=1, rsp_err=0, rsp_rdata = mem_rdata for a load, 0 for a store.
// - Accepted request with misaligned addr: mem_en=0. The next cycle gives rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0.
// - Fixed latency of 1 and fully pipelined: back-to-back accepts give back-to-back responses.
//   The response owner is held in a 1-deep register.
// - Simultaneous valid in ARB: ptr decides. Strict alternation holds while both ports stay valid.
// - mem_en=0 implies mem_we=0 and mem_addr/mem_wdata=0.
// TESTING
// - Reset then both ports load aligned addr 0x8/0x10 together: port0 granted cycle 1, port1 cycle 2.
//   rsp_valid arrives one cycle after each accept, with the matching data.
// - Port0 stores 0x8 to addr 0x0, then loads addr 0x0: the load response has rsp_rdata=0x8 and rsp_err=0.
// - Port1 loads addr 0x4: mem_en stays 0, and the next cycle has rsp_valid[1]=1, rsp_err[1]=1, rsp_rdata=0.
// - Port1 issues lock, lock, unlock while port0 is continuously valid: port0 is never ready until after the
//   unlock is accepted, and port0 is granted on the following cycle.
// - Port0 requests lock, then stays idle with port1 valid: after 16 cycles the state is forced to ARB and
//   port1 is granted on the next cycle.
// - Reset asserted the cycle after a load is accepted: no rsp_valid is produced, and ptr=0 after release.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle between the two DMEM requesters, the arbiter and the memory array.
// The arbiter sits on the slave modport; requesters and memory sit on the master modport.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [1:0]          req_lock;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_err;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit data memory between the core MEM stage (port 0) and the
// debug loader (port 1), with a bounded lock for atomic sequences and misalignment rejection.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             w_ptr_nxt;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_lock_cnt_nxt;

  logic             r_rsp_vld;
  logic             r_rsp_owner;
  logic             r_rsp_err;
  logic             r_rsp_load;

  logic             w_grant;
  logic             w_win;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic             w_we;
  logic             w_misaligned;
  logic             w_mem_go;
  logic             w_rsp_live;
  logic [1:0]       w_rsp_onehot;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ARB;
      r_ptr       <= 1'b0;
      r_lock_cnt  <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_owner <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_rsp_vld   <= w_grant;
      r_rsp_owner <= w_win;
      r_rsp_err   <= w_grant && w_misaligned;
      r_rsp_load  <= w_mem_go && !w_we;
    end
  end

  // A lock owner reaching LOCK_MAX is evicted that cycle even if it is requesting.
  always_comb begin
    w_grant        = 1'b0;
    w_win          = r_ptr;
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_lock_cnt_nxt = r_lock_cnt;
    unique case (r_state)
      ARB: begin
        if (bus.req_valid[r_ptr]) begin
          w_grant = 1'b1;
          w_win   = r_ptr;
        end else if (bus.req_valid[~r_ptr]) begin
          w_grant = 1'b1;
          w_win   = ~r_ptr;
        end
        if (w_grant) begin
          w_ptr_nxt = ~w_win;
          if (bus.req_lock[w_win]) begin
            w_state_nxt    = w_win ? LOCK1 : LOCK0;
            w_lock_cnt_nxt = CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        w_win = (r_state == LOCK1);
        if (r_lock_cnt == CNT_W'(LOCK_MAX)) begin
          w_state_nxt    = ARB;
          w_ptr_nxt      = ~w_win;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
          if (bus.req_valid[w_win]) begin
            w_grant   = 1'b1;
            w_ptr_nxt = ~w_win;
            if (!bus.req_lock[w_win]) begin
              w_state_nxt    = ARB;
              w_lock_cnt_nxt = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt    = ARB;
        w_lock_cnt_nxt = '0;
      end
    endcase
    if (!i_rst) begin
      w_grant = 1'b0;
    end
  end

  assign w_addr       = w_win ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
  assign w_wdata      = w_win ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
  assign w_we         = bus.req_we[w_win];
  assign w_misaligned = |w_addr[2:0];
  assign w_mem_go     = w_grant && !w_misaligned;

  assign bus.req_ready = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign bus.mem_en    = w_mem_go;
  assign bus.mem_we    = w_mem_go && w_we;
  assign bus.mem_addr  = w_mem_go ? w_addr  : '0;
  assign bus.mem_wdata = w_mem_go ? w_wdata : '0;

  // Responses still in the pipe while reset is held are suppressed and then flushed.
  assign w_rsp_live    = r_rsp_vld && i_rst;
  assign w_rsp_onehot  = r_rsp_owner ? 2'b10 : 2'b01;
  assign bus.rsp_valid = w_rsp_live ? w_rsp_onehot : 2'b00;
  assign bus.rsp_err   = (w_rsp_live && r_rsp_err) ? w_rsp_onehot : 2'b00;
  assign bus.rsp_rdata = (w_rsp_live && r_rsp_load) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a small registered-read memory model plus a linear
// sequence of hand-computed checks covering arbitration, lock, misalignment and reset.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] mem [0:15];

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory contents at reset: word i holds 0x1111*i.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'h1111 * i;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[6:3]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[6:3]];
    end
  end

  task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [1:0] we,
                               input logic [1:0] lk, input logic [63:0] a0, input logic [63:0] a1,
                               input logic [63:0] d0, input logic [63:0] d1);
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lk;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset with requests pending: everything quiet.
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("rst_ready", bus.req_ready, 2'b00);
    checkOutput("rst_mem_en", bus.mem_en, 1'b0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("rst_mem_addr", bus.mem_addr, 64'h0);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
    checkOutput("idle_ready", bus.req_ready, 2'b00);

    // Simultaneous loads: port0 first, then port1.
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("rr1_ready", bus.req_ready, 2'b01);
    checkOutput("rr1_mem_en", bus.mem_en, 1'b1);
    checkOutput("rr1_mem_addr", bus.mem_addr, 64'h8);
    checkOutput("rr1_rsp_valid", bus.rsp_valid, 2'b00);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("rr2_ready", bus.req_ready, 2'b10);
    checkOutput("rr2_mem_addr", bus.mem_addr, 64'h10);
    checkOutput("rr2_rsp_valid", bus.rsp_valid, 2'b01);
    checkOutput("rr2_rsp_rdata", bus.rsp_rdata, 64'h1111);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
    checkOutput("rr3_rsp_valid", bus.rsp_valid, 2'b10);
    checkOutput("rr3_rsp_rdata", bus.rsp_rdata, 64'h2222);
    checkOutput("rr3_mem_en", bus.mem_en, 1'b0);

    // Store then load back on port0.
    applyStimulus(1'b1, 2'b01, 2'b01, 2'b00, 64'h0, 64'h0, 64'h8, 64'h0);
    checkOutput("st_ready", bus.req_ready, 2'b01);
    checkOutput("st_mem_we", bus.mem_we, 1'b1);
    checkOutput("st_mem_wdata", bus.mem_wdata, 64'h8);
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
    checkOutput("ld_ready", bus.req_ready, 2'b01);
    checkOutput("ld_mem_we", bus.mem_we, 1'b0);
    checkOutput("st_rsp_valid", bus.rsp_valid, 2'b01);
    checkOutput("st_rsp_rdata", bus.rsp_rdata, 64'h0);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
    checkOutput("ld_rsp_valid", bus.rsp_valid, 2'b01);
    checkOutput("ld_rsp_err", bus.rsp_err, 2'b00);
    checkOutput("ld_rsp_rdata", bus.rsp_rdata, 64'h8);

    // Misaligned load on port1.
    applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 64'h0, 64'h4, 64'h0, 64'h0);
    checkOutput("mis_ready", bus.req_ready, 2'b10);
    checkOutput("mis_mem_en", bus.mem_en, 1'b0);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
    checkOutput("mis_rsp_valid", bus.rsp_valid, 2'b10);
    checkOutput("mis_rsp_err", bus.rsp_err, 2'b10);
    checkOutput("mis_rsp_rdata", bus.rsp_rdata, 64'h0);

    // Port1 lock, lock, unlock while port0 keeps requesting (ptr steered to 1 first).
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 64'h8, 64'h0, 64'h0, 64'h0);
    checkOutput("pre_ready", bus.req_ready, 2'b01);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b10, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("lk1_ready", bus.req_ready, 2'b10);
    checkOutput("lk1_rsp_rdata", bus.rsp_rdata, 64'h1111);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b10, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("lk2_ready", bus.req_ready, 2'b10);
    checkOutput("lk2_rsp_valid", bus.rsp_valid, 2'b10);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("unlk_ready", bus.req_ready, 2'b10);
    checkOutput("unlk_mem_en", bus.mem_en, 1'b1);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("post_unlk_ready", bus.req_ready, 2'b01);
    checkOutput("post_unlk_addr", bus.mem_addr, 64'h8);

    // Port0 takes the lock then goes idle; port1 waits out the 16-cycle bound.
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b01, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("hold_ready", bus.req_ready, 2'b01);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
      checkOutput($sformatf("held_ready_%0d", i), bus.req_ready, 2'b00);
    end
    applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("evict_ready", bus.req_ready, 2'b10);
    checkOutput("evict_mem_addr", bus.mem_addr, 64'h10);

    // Reset right after a load is accepted: the response is dropped and ptr returns to 0.
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("pre_rst_ready", bus.req_ready, 2'b01);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
    checkOutput("mid_rst_rsp_valid", bus.rsp_valid, 2'b00);
    checkOutput("mid_rst_rsp_rdata", bus.rsp_rdata, 64'h0);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0);
    checkOutput("post_rst_rsp_valid", bus.rsp_valid, 2'b00);
    checkOutput("post_rst_ptr_ready", bus.req_ready, 2'b01);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
    checkOutput("post_rst_rsp_rdata", bus.rsp_rdata, 64'h1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
